// File: rtl/dipole_scan_if.sv
// dipole_scan_if: host, evaluator and result signals of the dipole raster scanner.
// master = the scanner itself; slave = host/evaluator side.
interface dipole_scan_if #(
  parameter int WRITE_WIDTH  = 8,
  parameter int WRITE_HEIGHT = 8,
  parameter int RADIUS       = 4
);
  localparam int WIDTH       = WRITE_WIDTH + 2 * RADIUS;
  localparam int HEIGHT      = WRITE_HEIGHT + 2 * RADIUS;
  localparam int WIDTH_BITS  = $clog2(WIDTH);
  localparam int HEIGHT_BITS = $clog2(HEIGHT);
  localparam int NUM_WRITES  = WRITE_WIDTH * WRITE_HEIGHT;
  localparam int NUM_CELLS   = WIDTH * HEIGHT;

  logic                   start;
  logic [7:0]             passes;
  logic [NUM_WRITES-1:0]  pattern_strobe;
  logic [NUM_WRITES-1:0]  pattern_data;
  logic                   abort;
  logic                   write_valid;
  logic                   write_ready;
  logic [NUM_WRITES-1:0]  write_strobe;
  logic [NUM_WRITES-1:0]  write_data;
  logic [WIDTH_BITS-1:0]  dipole_x;
  logic [HEIGHT_BITS-1:0] dipole_y;
  logic                   dipole_update;
  logic                   dipole_value;
  logic                   busy;
  logic                   done;
  logic [NUM_CELLS-1:0]   dipole_map;
  logic [15:0]            flip_count;

  modport master (
    input  start, passes, pattern_strobe, pattern_data, abort,
           write_ready, dipole_update, dipole_value,
    output write_valid, write_strobe, write_data, dipole_x, dipole_y,
           busy, done, dipole_map, flip_count
  );

  modport slave (
    output start, passes, pattern_strobe, pattern_data, abort,
           write_ready, dipole_update, dipole_value,
    input  write_valid, write_strobe, write_data, dipole_x, dipole_y,
           busy, done, dipole_map, flip_count
  );
endinterface

// File: rtl/dipole_scan.sv
// dipole_scan: sweeps every cell of a (WRITE+2*RADIUS)^2 array in raster order
// for a programmable number of passes, issuing one evaluator request per cell
// and recording the evaluator's verdict in dipole_map.
// Optional feature: define DIPOLE_SCAN_STATS_EN to enable the flip_count
// statistic (otherwise flip_count is tied to zero).
module dipole_scan #(
  parameter int WRITE_WIDTH  = 8,
  parameter int WRITE_HEIGHT = 8,
  parameter int RADIUS       = 4
) (
  input logic           clk,
  input logic           reset,
  dipole_scan_if.master bus
);
  localparam int WIDTH       = WRITE_WIDTH + 2 * RADIUS;
  localparam int HEIGHT      = WRITE_HEIGHT + 2 * RADIUS;
  localparam int WIDTH_BITS  = $clog2(WIDTH);
  localparam int HEIGHT_BITS = $clog2(HEIGHT);
  localparam int NUM_WRITES  = WRITE_WIDTH * WRITE_HEIGHT;
  localparam int NUM_CELLS   = WIDTH * HEIGHT;
  localparam int CELL_BITS   = $clog2(NUM_CELLS);

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d;
  logic [7:0]             pass_q, pass_d;
  logic [NUM_WRITES-1:0]  strobe_q, strobe_d;
  logic [NUM_WRITES-1:0]  data_q, data_d;
  logic [NUM_CELLS-1:0]   map_q, map_d;

  logic                 accept;
  logic                 hs;
  logic                 last_col;
  logic                 last_row;
  logic [CELL_BITS-1:0] cell_idx;

  // abort dominates both a new start and a handshake in the same cycle
  assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
  assign hs       = (state_q == ISSUE) && bus.write_ready && !bus.abort;
  assign last_col = (x_q == WIDTH_BITS'(WIDTH - 1));
  assign last_row = (y_q == HEIGHT_BITS'(HEIGHT - 1));
  assign cell_idx = CELL_BITS'(y_q) * CELL_BITS'(WIDTH) + CELL_BITS'(x_q);

  // next-state, raster advance and map update
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    pass_d   = pass_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    map_d    = map_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.passes != 8'd0) begin
            state_d  = ISSUE;
            x_d      = '0;
            y_d      = '0;
            pass_d   = bus.passes;
            strobe_d = bus.pattern_strobe;
            data_d   = bus.pattern_data;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hs) begin
          if (bus.dipole_update) begin
            map_d[cell_idx] = bus.dipole_value;
          end
          if (last_col) begin
            x_d = '0;
            if (last_row) begin
              y_d    = '0;
              pass_d = pass_q - 8'd1;
              if (pass_q == 8'd1) begin
                state_d = FINISH;
              end
            end else begin
              y_d = y_q + HEIGHT_BITS'(1);
            end
          end else begin
            x_d = x_q + WIDTH_BITS'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      pass_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      map_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pass_q   <= pass_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      map_q    <= map_d;
    end
  end

  assign bus.write_valid  = (state_q == ISSUE);
  assign bus.busy         = (state_q != IDLE);
  // an abort landing in FINISH suppresses the done pulse
  assign bus.done         = (state_q == FINISH) && !bus.abort;
  assign bus.dipole_x     = x_q;
  assign bus.dipole_y     = y_q;
  assign bus.write_strobe = strobe_q;
  assign bus.write_data   = data_q;
  assign bus.dipole_map   = map_q;

`ifdef DIPOLE_SCAN_STATS_EN
  logic [15:0] flip_q, flip_d;

  // saturating count of map bits whose value actually changed
  always_comb begin
    flip_d = flip_q;
    if (accept) begin
      flip_d = '0;
    end else if (hs && bus.dipole_update &&
                 (bus.dipole_value != map_q[cell_idx]) && (flip_q != '1)) begin
      flip_d = flip_q + 16'd1;
    end
  end

  // flip counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      flip_q <= '0;
    end else begin
      flip_q <= flip_d;
    end
  end

  assign bus.flip_count = flip_q;
`else
  assign bus.flip_count = '0;
`endif
endmodule
